// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Purpose  : Shares one pipelined 35x25 multiplier, p = (a*b + c) >>> 17,
//            among NREQ requesters. A combinational arbiter picks one
//            requester per clock. Its operands are registered into the
//            multiplier, and its ID travels down a tag pipeline matched to
//            the multiplier latency, so each result is returned with the ID
//            of the requester that issued it.
// Ports    : clock, reset        - clock, asynchronous active-high reset
//            req_valid/req_ready - per-requester handshake (ready one-hot)
//            req_a/req_b/req_c   - packed operands, requester i at [W*i +: W]
//            mult_a/b/c, mult_p  - registered operands to / result from mult
//            res_valid/id/p      - tagged result strobe (no backpressure)
//            busy                - operation in issue stage or in flight
// Config   : MULT_ARB_FIXED_PRIO_EN - lowest index wins, no RR pointer
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = $clog2(NREQ),
    parameter int LATENCY = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*25-1:0]   req_a,
    input  logic [NREQ*35-1:0]   req_b,
    input  logic [NREQ*48-1:0]   req_c,
    output logic [24:0]          mult_a,
    output logic [34:0]          mult_b,
    output logic [47:0]          mult_c,
    input  logic [47:0]          mult_p,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [47:0]          res_p,
    output logic                 busy
);

    localparam int c_A_W = 25;
    localparam int c_B_W = 35;
    localparam int c_C_W = 48;

    logic              w_accept;
    logic [ID_W-1:0]   w_gid;
    logic [c_A_W-1:0]  w_sel_a;
    logic [c_B_W-1:0]  w_sel_b;
    logic [c_C_W-1:0]  w_sel_c;

    // Issue stage: valid/id registered alongside mult_a/b/c.
    logic              r_issue_v;
    logic [ID_W-1:0]   r_issue_id;

    // Tag pipeline; entry LATENCY-1 lines up with mult_p.
    logic [LATENCY-1:0] r_tag_v;
    logic [ID_W-1:0]    r_tag_id [LATENCY];

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        w_accept = 1'b0;
        w_gid    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_accept && req_valid[k]) begin
                w_accept = 1'b1;
                w_gid    = ID_W'(k);
            end
        end
    end
`else
    // Round robin: search starts one past the last granted index and wraps.
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        w_accept = 1'b0;
        w_gid    = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NREQ);
            if (!w_accept && req_valid[w_idx]) begin
                w_accept = 1'b1;
                w_gid    = w_idx;
            end
        end
    end

    // Pointer moves only when a request is actually taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= ID_W'(NREQ - 1);
        end else if (w_accept) begin
            r_last <= w_gid;
        end
    end
`endif

    // One-hot grant decode and operand mux (constant slices, no arithmetic).
    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_c   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gid == ID_W'(k)) begin
                req_ready[k] = w_accept;
                w_sel_a      = req_a[k*c_A_W +: c_A_W];
                w_sel_b      = req_b[k*c_B_W +: c_B_W];
                w_sel_c      = req_c[k*c_C_W +: c_C_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_a     <= '0;
            mult_b     <= '0;
            mult_c     <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= '0;
            r_tag_v    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_p      <= '0;
        end else begin
            // Issue stage: operands hold when nothing is accepted.
            r_issue_v <= w_accept;
            if (w_accept) begin
                mult_a     <= w_sel_a;
                mult_b     <= w_sel_b;
                mult_c     <= w_sel_c;
                r_issue_id <= w_gid;
            end

            // Tag shift register tracking the multiplier pipe.
            r_tag_v[0]  <= r_issue_v;
            r_tag_id[0] <= r_issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end

            // Result stage: capture mult_p only for tagged (real) results.
            res_valid <= r_tag_v[LATENCY-1];
            if (r_tag_v[LATENCY-1]) begin
                res_id <= r_tag_id[LATENCY-1];
                res_p  <= mult_p;
            end
        end
    end

    assign busy = r_issue_v | (|r_tag_v);

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Purpose  : Directed self-checking bench for mult_arbiter with a behavioural
//            multiplier p = (a*b + c) >>> 17 delayed by LATENCY clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 4;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*25-1:0]  req_a;
    logic [NREQ*35-1:0]  req_b;
    logic [NREQ*48-1:0]  req_c;
    logic [24:0]         mult_a;
    logic [34:0]         mult_b;
    logic [47:0]         mult_c;
    logic [47:0]         mult_p;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [47:0]         res_p;
    logic                busy;

    int nchk = 0;
    int nfail = 0;
    int nres;
    int seen;
    int q_id[$];
    logic [47:0] q_p[$];

    mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_c    (mult_c),
        .mult_p    (mult_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural multiplier.
    function automatic logic [47:0] mulf(input logic signed [24:0] a,
                                         input logic signed [34:0] b,
                                         input logic signed [47:0] c);
        logic signed [63:0] ea, eb, ec, t;
        ea = a;
        eb = b;
        ec = c;
        t  = (ea * eb + ec) >>> 17;
        return t[47:0];
    endfunction

    logic [47:0] mpipe [LATENCY];
    initial for (int i = 0; i < LATENCY; i++) mpipe[i] = '0;
    always @(posedge clock) begin
        mpipe[0] <= mulf(mult_a, mult_b, mult_c);
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_p = mpipe[LATENCY-1];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_collect();
        int eid;
        logic [47:0] ep;
        tick();
        if (res_valid) begin
            if (q_id.size() == 0) begin
                chk("spurious_result", 64'(res_valid), 64'd0);
            end else begin
                eid = q_id.pop_front();
                ep  = q_p.pop_front();
                chk("res_id_order", 64'(res_id), 64'(eid));
                chk("res_p_order", 64'(res_p), 64'(ep));
                nres++;
            end
        end
    endtask

    task automatic set_op(input int id, input logic [24:0] a,
                          input logic [34:0] b, input logic [47:0] c);
        req_a[25*id +: 25] = a;
        req_b[35*id +: 35] = b;
        req_c[48*id +: 48] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_id.delete();
        q_p.delete();
    endtask

    // Lone request: checks grant, exact result latency, tag and hold.
    task automatic single(input int id, input logic [24:0] a, input logic [34:0] b,
                          input logic [47:0] c, input logic [47:0] ep);
        set_op(id, a, b, c);
        req_valid = 4'(1) << id;
        #1;
        chk("single_ready", 64'(req_ready), 64'(1) << id);
        tick();
        req_valid = '0;
        chk("single_mult_a", 64'(mult_a), 64'(a));
        chk("single_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("single_early", 64'(res_valid), 64'd0);
        end
        tick();
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_id", 64'(res_id), 64'(id));
        chk("single_p", 64'(res_p), 64'(ep));
        tick();
        chk("single_strobe", 64'(res_valid), 64'd0);
        chk("single_hold", 64'(res_p), 64'(ep));
        chk("single_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int eg;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        chk("rst_mult_b", 64'(mult_b), 64'd0);
        chk("rst_mult_c", 64'(mult_c), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_res_p", 64'(res_p), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;

        // 1: lone requester 1, 3 * 2^18 >>> 17 = 6.
        single(1, 25'd3, 35'h40000, 48'd0, 48'd6);

        // 2: all four requesting for 12 cycles from a fresh pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 25'(i + 1), 35'h20000, 48'd0);
        nres = 0;
        req_valid = 4'hF;
        for (int n = 0; n < 12; n++) begin
            #1;
            chk("rr4_ready", 64'(req_ready), 64'(1) << (n % 4));
            q_id.push_back(n % 4);
            q_p.push_back(48'((n % 4) + 1));
            tick_collect();
            chk("rr4_busy", 64'(busy), 64'd1);
        end
        req_valid = '0;
        repeat (8) tick_collect();
        chk("rr4_count", 64'(nres), 64'd12);

        // 3: sign handling and addend-only path.
        single(2, 25'h1FFFFFF, 35'h20000, 48'd0, 48'hFFFF_FFFF_FFFF);
        single(2, 25'd0, 35'd0, 48'h60000, 48'd3);

        // 4: reset while three results are in flight.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 25'(i + 1), 35'h20000, 48'd0);
        req_valid = 4'b0111;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("flight_ready", 64'(req_ready), 64'(1) << n);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_mult_a", 64'(mult_a), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (res_valid) seen++;
        end
        chk("midrst_no_results", 64'(seen), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);

        // 5: requesters 0 and 2 continuously.
        do_reset();
        set_op(0, 25'd5, 35'h20000, 48'd0);
        set_op(2, 25'd3, 35'h20000, 48'd0);
        nres = 0;
        req_valid = 4'b0101;
        for (int n = 0; n < 6; n++) begin
            #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
            eg = 0;
`else
            eg = (n % 2 == 0) ? 0 : 2;
`endif
            chk("pair_ready", 64'(req_ready), 64'(1) << eg);
            q_id.push_back(eg);
            q_p.push_back((eg == 0) ? 48'd5 : 48'd3);
            tick_collect();
        end
        req_valid = '0;
        repeat (8) tick_collect();
        chk("pair_count", 64'(nres), 64'd6);

        // 6: requester 3 pulses one cycle while 0 holds; 3 is dropped.
        do_reset();
        set_op(3, 25'd7, 35'h20000, 48'd0);
        nres = 0;
        req_valid = 4'b1001;
        #1;
        chk("drop_ready0", 64'(req_ready), 64'd1);
        q_id.push_back(0);
        q_p.push_back(48'd5);
        tick_collect();
        req_valid = 4'b0001;
        #1;
        chk("drop_ready1", 64'(req_ready), 64'd1);
        q_id.push_back(0);
        q_p.push_back(48'd5);
        tick_collect();
        req_valid = '0;
        repeat (8) tick_collect();
        chk("drop_count", 64'(nres), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
